// File: rtl/pair_seq_pkg.sv
// Shared definitions for the pair sequencer: default geometry, FSM state encoding
// and the WAIT down-counter load value.
package pair_seq_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  // WAIT counts down to zero, so it is loaded with one less than the latency.
  function automatic logic [2:0] wait_load(input int lat);
    return 3'(lat - 1);
  endfunction

endpackage

// File: rtl/pair_sequencer_if.sv
// Request/datapath/status bundle of the pair sequencer. The master side issues
// requests and returns datapath results; the slave side is the sequencer.
interface pair_sequencer_if
  import pair_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] first_adr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] dp_out;
  logic [ADDR_W-1:0] adr1;
  logic [ADDR_W-1:0] adr2;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic [DATA_W+1:0] acc;
  logic              done;

  modport master (
    output start, first_adr, count, dp_out,
    input  adr1, adr2, busy, result, acc, done
  );

  modport slave (
    input  start, first_adr, count, dp_out,
    output adr1, adr2, busy, result, acc, done
  );

endinterface

// File: rtl/pair_seq_acc.sv
// Running-sum accumulator for captured datapath results.
// Define PAIR_SEQ_SAT_EN to saturate at all-ones; otherwise the sum wraps.
module pair_seq_acc
  import pair_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W+1:0] acc
);

  logic [DATA_W+1:0] acc_q;
  logic [DATA_W+1:0] acc_d;
  logic [DATA_W+1:0] add_val;

`ifdef PAIR_SEQ_SAT_EN
  // One extra carry bit tells us the sum left the representable range.
  logic [DATA_W+2:0] sum_val;
  assign sum_val = {1'b0, acc_q} + {3'b000, din};
  assign add_val = sum_val[DATA_W+2] ? '1 : sum_val[DATA_W+1:0];
`else
  assign add_val = acc_q + {2'b00, din};
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = add_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pair_sequencer.sv
// Walks count address pairs (first_adr+2k, first_adr+2k+1) through a fixed-latency
// datapath, capturing and summing results. Build option: PAIR_SEQ_SAT_EN (acc saturates).
module pair_sequencer
  import pair_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = DEF_LAT
) (
  input logic             clk,
  input logic             rst,
  pair_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr1_q, adr1_d;
  logic [ADDR_W-1:0] adr2_q, adr2_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              acc_clr;
  logic              acc_add;

  always_comb begin
    state_d  = state_q;
    adr1_d   = adr1_q;
    adr2_d   = adr2_q;
    count_d  = count_q;
    k_d      = k_q;
    wait_d   = wait_q;
    result_d = result_q;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_clr = 1'b1;
          k_d     = '0;
          if (bus.count != '0) begin
            count_d = bus.count;
            adr1_d  = bus.first_adr;
            adr2_d  = ADDR_W'(bus.first_adr + 1'b1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        wait_d  = wait_load(LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_CAPTURE: begin
        result_d = bus.dp_out;
        acc_add  = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_d == count_q) begin
          state_d = ST_DONE;
        end else begin
          // Next pair sits two addresses further on; ADDR_W-bit math gives the wrap.
          adr1_d  = adr1_q + ADDR_W'(2);
          adr2_d  = adr2_q + ADDR_W'(2);
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      adr1_q   <= '0;
      adr2_q   <= '0;
      count_q  <= '0;
      k_q      <= '0;
      wait_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr1_q   <= adr1_d;
      adr2_q   <= adr2_d;
      count_q  <= count_d;
      k_q      <= k_d;
      wait_q   <= wait_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  pair_seq_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .add_en (acc_add),
    .din    (bus.dp_out),
    .acc    (bus.acc)
  );

  assign bus.adr1   = adr1_q;
  assign bus.adr2   = adr2_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
